uart_rx_byte: RTL

- Synthesizable 8N1 UART receiver.
- Decodes the serial line leaving the design (usb_uart_txd) into bytes, so the bench and on-board logic can check what the design transmits.
- Presents each byte on a single-entry valid/ready output register.
- Sits beside design_1_wrapper, in the bench or as a custom IP, on the same sys_clock domain.

---
 rtl/uart_rx_byte_pkg.sv | 17 +
 rtl/uart_rx_byte_sync_ff.sv | 25 ++
 rtl/uart_rx_byte.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the 8N1 UART byte receiver: FSM encoding, frame
// geometry and the default bit period for a 100 MHz clock at 115200 baud.
package uart_rx_byte_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;
  localparam int IDX_W                = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte_sync_ff.sv
// Parameterized-depth synchronizer for asynchronous single-bit inputs; flops
// preset high so an idle-high line never looks active coming out of reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw input through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a single-entry valid/ready
// holding register, with framing-error and overrun pulses.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]    HALF_C     = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]    FULL_C     = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]    ONE_C      = TW'(1);
  localparam logic [IDX_W-1:0] LAST_BIT_C = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE_C  = IDX_W'(1);

  rx_state_e            state_r;
  logic [TW-1:0]        timer_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 done_r;
  logic                 rs_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (sys_clock),
    .rst_n (reset),
    .d     (rxd),
    .q     (rs_s)
  );

  // Frame FSM; the timer reloads at every sample point so bit timing never drifts
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      done_r    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          timer_r   <= '0;
          bit_idx_r <= '0;
          if (!rs_s) begin
            state_r <= START;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (timer_r == HALF_C) begin
            timer_r <= '0;
            if (rs_s) begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_r   <= DATA;
              bit_idx_r <= '0;
            end
          end else begin
            timer_r <= timer_r + ONE_C;
          end
        end
        DATA: begin
          if (timer_r == FULL_C) begin
            timer_r            <= '0;
            shift_r[bit_idx_r] <= rs_s;
            if (bit_idx_r == LAST_BIT_C) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + IDX_ONE_C;
            end
          end else begin
            timer_r <= timer_r + ONE_C;
          end
        end
        STOP: begin
          if (timer_r == FULL_C) begin
            timer_r <= '0;
            if (rs_s) begin
              done_r  <= 1'b1;
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_r   <= WAIT_HIGH;
            end
          end else begin
            timer_r <= timer_r + ONE_C;
          end
        end
        WAIT_HIGH: begin
          // Line held low (break): wait silently for it to return to idle
          if (rs_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          timer_r <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: a same-cycle accept makes room for the new byte
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_r) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
